// File: rtl/rejudge_entry.sv
// rejudge_entry: operator entry block for the rejudge feature.
// Four raw push buttons are synchronised, debounced and edge-detected. A
// small FSM then steps through player / problem / score, and a commit loads
// the values into the registers that the rejudge display reads.
// Optional build macro: REJUDGE_AUTOREPEAT_EN adds hold-to-repeat on inc/dec.
//
// state   | meaning
// --------+------------------------------------------
// S_IDLE  | waiting for ok to open an edit session
// S_PL    | editing player index (0..3, wraps)
// S_PB    | editing problem ID (1..MAX_PROBLEM, wraps)
// S_SC    | editing score (0..MAX_SCORE, saturates)
module rejudge_entry #(
  parameter int DEB_CYCLES    = 500000,
  parameter int MAX_PROBLEM   = 99,
  parameter int MAX_SCORE     = 99,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ok,
  input  logic       btn_back,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [1:0] player,
  output logic [7:0] problemID,
  output logic [7:0] score,
  output logic       valid,
  output logic [1:0] phase,
  output logic [7:0] edit_value
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PL   = 2'd1,
    S_PB   = 2'd2,
    S_SC   = 2'd3
  } state_t;

  // bit order: 0 = ok, 1 = back, 2 = inc, 3 = dec
  logic [3:0]    raw, sync1, sync2, deb, deb_d, press;
  logic [CW-1:0] deb_cnt [4];

  logic ev_ok, ev_back, ev_inc, ev_dec, step_up, step_dn;

  state_t     state_q, state_d;
  logic [1:0] w_pl, w_pl_d;
  logic [7:0] w_pb, w_pb_d, w_sc, w_sc_d, edit_d;
  logic       commit;

  assign raw = {btn_dec, btn_inc, btn_back, btn_ok};

  // Synchronise, debounce (level flips after DEB_CYCLES of disagreement) and
  // register a one-cycle pulse on each debounced rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign ev_ok   = press[0];
  assign ev_back = press[1];

`ifdef REJUDGE_AUTOREPEAT_EN
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_armed, rep_pulse, rep_run;

  // Repeat only while held inside an edit state with no state change pending.
  assign rep_run = deb[3:2] & {2{(state_q != S_IDLE) && (state_d == state_q)}};

  // Per-button repeat timer: first extra event after HOLD_CYCLES, then one
  // every REPEAT_CYCLES; index 0 = inc, 1 = dec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_armed <= '0;
      rep_pulse <= '0;
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_pulse[i] <= 1'b0;
        if (!rep_run[i]) begin
          rep_cnt[i]   <= '0;
          rep_armed[i] <= 1'b0;
        end else if ((!rep_armed[i] && rep_cnt[i] == RW'(HOLD_CYCLES - 1)) ||
                     ( rep_armed[i] && rep_cnt[i] == RW'(REPEAT_CYCLES - 1))) begin
          rep_pulse[i] <= 1'b1;
          rep_cnt[i]   <= '0;
          rep_armed[i] <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev_inc = press[2] | rep_pulse[0];
  assign ev_dec = press[3] | rep_pulse[1];
`else
  assign ev_inc = press[2];
  assign ev_dec = press[3];
`endif

  // inc and dec together cancel out.
  assign step_up = ev_inc & ~ev_dec;
  assign step_dn = ev_dec & ~ev_inc;

  // Next state and working values; back beats ok beats inc/dec.
  always_comb begin
    state_d = state_q;
    w_pl_d  = w_pl;
    w_pb_d  = w_pb;
    w_sc_d  = w_sc;
    commit  = 1'b0;
    edit_d  = 8'd0;
    case (state_q)
      S_IDLE: if (ev_ok) state_d = S_PL;
      S_PL: begin
        if (ev_back)      state_d = S_IDLE;
        else if (ev_ok)   state_d = S_PB;
        else if (step_up) w_pl_d  = w_pl + 2'd1;
        else if (step_dn) w_pl_d  = w_pl - 2'd1;
      end
      S_PB: begin
        if (ev_back)      state_d = S_PL;
        else if (ev_ok)   state_d = S_SC;
        else if (step_up) w_pb_d  = (w_pb >= 8'(MAX_PROBLEM)) ? 8'd1 : w_pb + 8'd1;
        else if (step_dn) w_pb_d  = (w_pb <= 8'd1) ? 8'(MAX_PROBLEM) : w_pb - 8'd1;
      end
      S_SC: begin
        if (ev_back) state_d = S_PB;
        else if (ev_ok) begin
          state_d = S_IDLE;
          commit  = 1'b1;
        end
        else if (step_up && w_sc < 8'(MAX_SCORE)) w_sc_d = w_sc + 8'd1;
        else if (step_dn && w_sc != 8'd0)         w_sc_d = w_sc - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_PL:    edit_d = {6'd0, w_pl_d};
      S_PB:    edit_d = w_pb_d;
      S_SC:    edit_d = w_sc_d;
      default: edit_d = 8'd0;
    endcase
  end

  // State, working, committed and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      w_pl       <= 2'd0;
      w_pb       <= 8'd1;
      w_sc       <= 8'd0;
      player     <= 2'd0;
      problemID  <= 8'd1;
      score      <= 8'd0;
      valid      <= 1'b0;
      edit_value <= 8'd0;
    end else begin
      state_q    <= state_d;
      w_pl       <= w_pl_d;
      w_pb       <= w_pb_d;
      w_sc       <= w_sc_d;
      valid      <= commit;
      edit_value <= edit_d;
      if (commit) begin
        player    <= w_pl_d;
        problemID <= w_pb_d;
        score     <= w_sc_d;
      end
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_rejudge_entry.sv
// Bench for rejudge_entry: committed records are checked through a queue of
// expected (player, problem, score) entries popped on every valid pulse.
module tb_rejudge_entry;
  localparam int DEB = 4, MAXP = 12, MAXS = 10, HOLD = 20, REP = 5;
`ifdef REJUDGE_AUTOREPEAT_EN
  localparam int EXP_REP = 5;
`else
  localparam int EXP_REP = 1;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic btn_ok = 1'b0, btn_back = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [1:0] player, phase;
  logic [7:0] problemID, score, edit_value;
  logic valid;

  int checks = 0, failures = 0, valid_cnt = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_rec;

  always #5 clk = ~clk;

  rejudge_entry #(
    .DEB_CYCLES(DEB), .MAX_PROBLEM(MAXP), .MAX_SCORE(MAXS),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_ok(btn_ok), .btn_back(btn_back),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .player(player),
    .problemID(problemID), .score(score), .valid(valid),
    .phase(phase), .edit_value(edit_value)
  );

  // scoreboard: every valid cycle must match the next expected record
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL valid_unexpected got pl=%0d pb=%0d sc=%0d required no valid",
                 player, problemID, score);
      end else begin
        exp_rec = exp_q.pop_front();
        if ({player, problemID, score} !== exp_rec) begin
          failures++;
          $display("FAIL commit_record got pl=%0d pb=%0d sc=%0d required pl=%0d pb=%0d sc=%0d",
                   player, problemID, score, exp_rec[17:16], exp_rec[15:8], exp_rec[7:0]);
        end
      end
    end
  end

  // hold a button pattern long enough to debounce, then release and settle
  task automatic press(input logic [3:0] m);
    {btn_dec, btn_inc, btn_back, btn_ok} = m;
    repeat (10) @(negedge clk);
    {btn_dec, btn_inc, btn_back, btn_ok} = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (phase !== 2'd0) begin failures++; $display("FAIL reset_phase got=%0d required=0", phase); end
    checks++;
    if (edit_value !== 8'd0) begin failures++; $display("FAIL reset_edit got=%0d required=0", edit_value); end
    checks++;
    if ({player, problemID, score} !== {2'd0, 8'd1, 8'd0}) begin
      failures++; $display("FAIL reset_committed got=%0d/%0d/%0d required=0/1/0", player, problemID, score);
    end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d required=0", valid); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_ok;
    press(4'b0001);
    checks++;
    if (phase !== 2'd1 || edit_value !== 8'd0) begin
      failures++; $display("FAIL first_ok got phase=%0d edit=%0d required phase=1 edit=0", phase, edit_value);
    end
    checks++;
    if ({player, problemID, score} !== {2'd0, 8'd1, 8'd0}) begin
      failures++; $display("FAIL first_ok_committed got=%0d/%0d/%0d required=0/1/0", player, problemID, score);
    end
  endtask

  task automatic test_commit_flow;
    int v0;
    press(4'b0100); press(4'b0100);
    checks++;
    if (edit_value !== 8'd2) begin failures++; $display("FAIL pl_inc got=%0d required=2", edit_value); end
    press(4'b0001);
    press(4'b1000);
    checks++;
    if (phase !== 2'd2 || edit_value !== 8'd12) begin
      failures++; $display("FAIL pb_dec_wrap got phase=%0d edit=%0d required phase=2 edit=12", phase, edit_value);
    end
    press(4'b0001);
    for (int i = 0; i < 3; i++) press(4'b0100);
    checks++;
    if (phase !== 2'd3 || edit_value !== 8'd3) begin
      failures++; $display("FAIL sc_inc got phase=%0d edit=%0d required phase=3 edit=3", phase, edit_value);
    end
    v0 = valid_cnt;
    exp_q.push_back({2'd2, 8'd12, 8'd3});
    press(4'b0001);
    checks++;
    if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL commit_pulses got=%0d required=1", valid_cnt - v0); end
    checks++;
    if (phase !== 2'd0 || edit_value !== 8'd0) begin
      failures++; $display("FAIL after_commit got phase=%0d edit=%0d required phase=0 edit=0", phase, edit_value);
    end
  endtask

  task automatic test_bounds;
    press(4'b0001);
    checks++;
    if (edit_value !== 8'd2) begin failures++; $display("FAIL session_resume got=%0d required=2", edit_value); end
    press(4'b0001);
    press(4'b0100);
    checks++;
    if (edit_value !== 8'd1) begin failures++; $display("FAIL pb_inc_wrap got=%0d required=1", edit_value); end
    press(4'b1000);
    checks++;
    if (edit_value !== 8'd12) begin failures++; $display("FAIL pb_dec_wrap2 got=%0d required=12", edit_value); end
    press(4'b0001);
    for (int i = 0; i < 4; i++) press(4'b1000);
    checks++;
    if (edit_value !== 8'd0) begin failures++; $display("FAIL sc_sat_low got=%0d required=0", edit_value); end
    for (int i = 0; i < 12; i++) press(4'b0100);
    checks++;
    if (edit_value !== 8'd10) begin failures++; $display("FAIL sc_sat_high got=%0d required=10", edit_value); end
    press(4'b0010);
    checks++;
    if (phase !== 2'd2 || edit_value !== 8'd12) begin
      failures++; $display("FAIL back_to_pb got phase=%0d edit=%0d required phase=2 edit=12", phase, edit_value);
    end
    press(4'b0010); press(4'b0010);
    checks++;
    if (phase !== 2'd0 || {player, problemID, score} !== {2'd2, 8'd12, 8'd3}) begin
      failures++; $display("FAIL cancel got phase=%0d rec=%0d/%0d/%0d required phase=0 rec=2/12/3",
                           phase, player, problemID, score);
    end
  endtask

  task automatic test_bounce;
    int n;
    press(4'b0001);
    for (int i = 0; i < 20; i++) begin
      btn_inc = ((i % 4) < 2);
      @(negedge clk);
    end
    checks++;
    if (edit_value !== 8'd2) begin failures++; $display("FAIL bounce_ignored got=%0d required=2", edit_value); end
    btn_inc = 1'b1;
    n = 0;
    while (edit_value === 8'd2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 8) begin failures++; $display("FAIL bounce_latency got=%0d required=8", n); end
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (edit_value !== 8'd3) begin failures++; $display("FAIL bounce_single got=%0d required=3", edit_value); end
    press(4'b0010);
  endtask

  task automatic test_simultaneous;
    press(4'b0001);
    press(4'b0011);
    checks++;
    if (phase !== 2'd0 || {player, problemID, score} !== {2'd2, 8'd12, 8'd3}) begin
      failures++; $display("FAIL back_ok_same got phase=%0d rec=%0d/%0d/%0d required phase=0 rec=2/12/3",
                           phase, player, problemID, score);
    end
    press(4'b0001); press(4'b0001);
    press(4'b1100);
    checks++;
    if (phase !== 2'd2 || edit_value !== 8'd12) begin
      failures++; $display("FAIL inc_dec_same got phase=%0d edit=%0d required phase=2 edit=12", phase, edit_value);
    end
    press(4'b0010); press(4'b0010);
  endtask

  task automatic test_repeat;
    press(4'b0001); press(4'b0001); press(4'b0001);
    for (int i = 0; i < 10; i++) press(4'b1000);
    checks++;
    if (phase !== 2'd3 || edit_value !== 8'd0) begin
      failures++; $display("FAIL sc_to_zero got phase=%0d edit=%0d required phase=3 edit=0", phase, edit_value);
    end
    btn_inc = 1'b1;
    repeat (37) @(negedge clk);
    btn_inc = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (edit_value !== 8'(EXP_REP)) begin
      failures++; $display("FAIL hold_inc got=%0d required=%0d", edit_value, EXP_REP);
    end
    exp_q.push_back({2'd3, 8'd12, 8'(EXP_REP)});
    press(4'b0001);
    checks++;
    if (score !== 8'(EXP_REP)) begin failures++; $display("FAIL hold_commit got=%0d required=%0d", score, EXP_REP); end
  endtask

  task automatic test_reset_mid;
    press(4'b0001);
    btn_inc = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (phase !== 2'd1 || edit_value !== 8'd0) begin
      failures++; $display("FAIL midhold_pre got phase=%0d edit=%0d required phase=1 edit=0", phase, edit_value);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (phase !== 2'd0 || edit_value !== 8'd0 || valid !== 1'b0) begin
      failures++; $display("FAIL midreset_state got phase=%0d edit=%0d valid=%0d required 0/0/0", phase, edit_value, valid);
    end
    checks++;
    if ({player, problemID, score} !== {2'd0, 8'd1, 8'd0}) begin
      failures++; $display("FAIL midreset_committed got=%0d/%0d/%0d required=0/1/0", player, problemID, score);
    end
    btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    press(4'b0001);
    checks++;
    if (edit_value !== 8'd0) begin failures++; $display("FAIL midreset_wpl got=%0d required=0", edit_value); end
    press(4'b0001);
    checks++;
    if (edit_value !== 8'd1) begin failures++; $display("FAIL midreset_wpb got=%0d required=1", edit_value); end
    press(4'b0010); press(4'b0010);
  endtask

  initial begin
    test_reset();
    test_first_ok();
    test_commit_flow();
    test_bounds();
    test_bounce();
    test_simultaneous();
    test_repeat();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL pending_commits got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
